// File: rtl/mem_1d_stream_reader_pkg.sv
// mem_1d_stream_reader_pkg: shared sizes and FSM encoding for the 1-D result memory and its reader
package mem_1d_stream_reader_pkg;
    localparam int PKG_DW       = 8;
    localparam int PKG_MEM_SIZE = 14;
    localparam int PKG_MEM_ADDR = 4;
    localparam int PKG_WW       = PKG_DW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/mem_1d_argmax.sv
// mem_1d_argmax: running signed maximum and its index; ties keep the earliest index
module mem_1d_argmax
    import mem_1d_stream_reader_pkg::*;
#(
    parameter int W  = PKG_WW,
    parameter int AW = PKG_MEM_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic signed [W-1:0] value_i,
    input  logic [AW-1:0]       index_i,
    output logic signed [W-1:0] max_value_o,
    output logic [AW-1:0]       max_index_o
);
    logic                have_q, have_d;
    logic signed [W-1:0] val_q, val_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                take;

    // the first word after clear always wins, later ones only if strictly greater
    always_comb begin
        take   = load_i && (!have_q || value_i > val_q);
        have_d = clear_i ? 1'b0 : (have_q || load_i);
        val_d  = take ? value_i : val_q;
        idx_d  = take ? index_i : idx_q;
    end

    // tracker registers, cleared by reset only so results persist past done
    always_ff @(posedge clk) begin
        if (!reset) begin
            have_q <= 1'b0;
            val_q  <= '0;
            idx_q  <= '0;
        end else begin
            have_q <= have_d;
            val_q  <= val_d;
            idx_q  <= idx_d;
        end
    end

    assign max_value_o = val_q;
    assign max_index_o = idx_q;
endmodule

// File: rtl/mem_1d_stream_reader.sv
// mem_1d_stream_reader: streams the 1-D memory in address order over valid/ready while tracking argmax
module mem_1d_stream_reader
    import mem_1d_stream_reader_pkg::*;
#(
    parameter int DW       = PKG_DW,
    parameter int MEM_SIZE = PKG_MEM_SIZE,
    parameter int MEM_ADDR = PKG_MEM_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 read_en,
    output logic [MEM_ADDR-1:0]  out_address,
    input  logic signed [DW:0]   mem_data,
    output logic signed [DW:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW:0]   max_value,
    output logic [MEM_ADDR-1:0]  max_index
);
    state_t               state_q, state_d;
    logic [MEM_ADDR-1:0]  addr_q, addr_d;
    logic signed [DW:0]   data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 load, clear, last_addr;

    // next-state: the output register refills whenever it is empty or being consumed
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        clear     = (state_q == S_IDLE) && start;
        load      = (state_q == S_READ) && (!valid_q || m_ready);
        last_addr = addr_q == MEM_ADDR'(MEM_SIZE - 1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                if (load) begin
                    data_d  = mem_data;
                    valid_d = 1'b1;
                    last_d  = last_addr;
                    addr_d  = addr_q + 1'b1;
                    if (last_addr) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (valid_q && m_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state, address and output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    mem_1d_argmax #(.W(DW + 1), .AW(MEM_ADDR)) u_argmax (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear),
        .load_i      (load),
        .value_i     (mem_data),
        .index_i     (addr_q),
        .max_value_o (max_value),
        .max_index_o (max_index)
    );

    assign read_en     = state_q == S_READ;
    assign out_address = read_en ? addr_q : '0;
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign m_data      = data_q;
    assign m_valid     = valid_q;
    assign m_last      = last_q;
endmodule

// File: tb/tb_mem_1d_stream_reader.sv
// tb_mem_1d_stream_reader: directed scoreboard bench for the 1-D stream reader
module tb_mem_1d_stream_reader;
    localparam int DW = 8;
    localparam int N  = 14;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic m_ready = 1'b1;
    logic read_en, m_valid, m_last, busy, done;
    logic [AW-1:0] out_address, max_index;
    logic signed [DW:0] mem_data, m_data, max_value;
    logic signed [DW:0] mem [16];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int sb_d[$];
    int sb_l[$];
    bit tog = 1'b0;
    int tog_ph = 0;
    bit stalled = 1'b0;
    int held_d = 0;
    int held_l = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[out_address];

    mem_1d_stream_reader #(.DW(DW), .MEM_SIZE(N), .MEM_ADDR(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .read_en     (read_en),
        .out_address (out_address),
        .mem_data    (mem_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done),
        .max_value   (max_value),
        .max_index   (max_index)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // samples outputs mid-cycle (after negedge), then advances one clock
    task automatic tick();
        if (tog) begin
            m_ready = (tog_ph == 0);
            tog_ph = (tog_ph + 1) % 3;
        end
        if (stalled) begin
            chk("stall_data", int'(m_data), held_d);
            chk("stall_last", int'(m_last), held_l);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (m_valid && m_ready) begin
            if (sb_d.size() == 0) chk("unexpected_word", int'(m_data), -9999);
            else begin
                chk("word_data", int'(m_data), sb_d.pop_front());
                chk("word_last", int'(m_last), sb_l.pop_front());
            end
        end
        stalled = m_valid && !m_ready && reset;
        held_d = int'(m_data);
        held_l = int'(m_last);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic push_pass();
        for (int i = 0; i < N; i++) begin
            sb_d.push_back(int'(mem[i]));
            sb_l.push_back(i == N - 1 ? 1 : 0);
        end
    endtask

    task automatic pulse_start();
        push_pass();
        start = 1'b1;
        start_cyc = cyc_n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < budget && done_cnt == d0; n++) tick();
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) mem[i] = (DW + 1)'(i);
    endtask

    initial begin
        int d0;
        bit found;
        load_ramp();
        @(negedge clk);
        tick();
        tick();
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_read_en", int'(read_en), 0);
        chk("rst_out_address", int'(out_address), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_max_value", int'(max_value), 0);
        chk("rst_max_index", int'(max_index), 0);
        reset = 1'b1;
        tick();

        // ramp pass with the consumer always ready
        pulse_start();
        chk("a_busy", int'(busy), 1);
        chk("a_read_en", int'(read_en), 1);
        chk("a_addr0", int'(out_address), 0);
        chk("a_valid_early", int'(m_valid), 0);
        tick();
        chk("a_first_valid", int'(m_valid), 1);
        chk("a_first_data", int'(m_data), 0);
        wait_done(60);
        // start cycle through done cycle inclusive spans N+3 cycles
        chk("a_done_latency", done_cyc - start_cyc, N + 2);
        chk("a_sb_empty", sb_d.size(), 0);
        chk("a_max_value", int'(max_value), 13);
        chk("a_max_index", int'(max_index), 13);
        tick();
        chk("a_busy_after", int'(busy), 0);
        chk("a_done_once", int'(done), 0);

        // consumer ready pattern 1,0,0 repeating
        tog = 1'b1;
        tog_ph = 0;
        pulse_start();
        wait_done(120);
        tog = 1'b0;
        m_ready = 1'b1;
        stalled = 1'b0;
        chk("t_sb_empty", sb_d.size(), 0);
        chk("t_max_index", int'(max_index), 13);
        tick();

        // tie on the maximum keeps the lower index
        for (int i = 0; i < 16; i++) mem[i] = -9'sd256;
        mem[0] = -9'sd5;
        mem[1] = -9'sd3;
        mem[2] = -9'sd3;
        mem[3] = -9'sd200;
        pulse_start();
        wait_done(60);
        chk("tie_sb_empty", sb_d.size(), 0);
        chk("tie_max_value", int'(max_value), -3);
        chk("tie_max_index", int'(max_index), 1);
        tick();
        chk("tie_hold_value", int'(max_value), -3);
        chk("tie_hold_index", int'(max_index), 1);

        // second start mid-pass is ignored
        load_ramp();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        d0 = done_cnt;
        wait_done(60);
        chk("mid_done_latency", done_cyc - start_cyc, N + 2);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_single_done", done_cnt - d0, 1);
        chk("mid_sb_empty", sb_d.size(), 0);
        chk("mid_idle", int'(busy), 0);

        // reset while word 6 is presented aborts the pass
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_valid && m_data == 9'sd6) found = 1'b1;
            else tick();
        end
        chk("rst_word6_found", int'(found), 1);
        d0 = done_cnt;
        m_ready = 1'b0;
        reset = 1'b0;
        tick();
        chk("abort_m_valid", int'(m_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_read_en", int'(read_en), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b1;
        m_ready = 1'b1;
        sb_d.delete();
        sb_l.delete();
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        pulse_start();
        chk("restart_addr0", int'(out_address), 0);
        wait_done(60);
        chk("restart_sb_empty", sb_d.size(), 0);
        tick();

        // long stall on word 0
        m_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10 && !m_valid; i++) tick();
        chk("bp_valid", int'(m_valid), 1);
        for (int i = 0; i < 20; i++) begin
            chk("bp_read_en", int'(read_en), 1);
            chk("bp_addr", int'(out_address), 1);
            chk("bp_data", int'(m_data), 0);
            tick();
        end
        m_ready = 1'b1;
        wait_done(60);
        chk("bp_sb_empty", sb_d.size(), 0);
        chk("bp_max_value", int'(max_value), 13);
        chk("bp_max_index", int'(max_index), 13);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
